// File: rtl/if_pc_gen_pkg.sv
// Shared types and constants for the IF-stage fetch address generator.
// Address width, BTB geometry, reset PC default and the fetch FSM encoding.
package if_pc_gen_pkg;

  localparam int InstAddrBus = 32;
  localparam int BtbIdxW     = 6;
  localparam int BtbTagW     = InstAddrBus - BtbIdxW - 2;

  localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [InstAddrBus-1:0] pc_plus4(input logic [InstAddrBus-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_pc_gen_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup, posedge write port,
// valid bits cleared asynchronously by rst. Word-aligned PCs only (bits [31:2]).
module if_pc_gen_btb_table
  import if_pc_gen_pkg::*;
#(
  parameter int IDX_W = BtbIdxW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] lookup_pc_i,
  output logic        hit_o,
  output logic [31:0] target_o,
  input  logic        we_i,
  input  logic [31:2] wpc_i,
  input  logic [31:0] wtarget_i
);

  localparam int Entries = 1 << IDX_W;
  localparam int TagW    = 32 - IDX_W - 2;

  logic [Entries-1:0] r_valid;
  logic [TagW-1:0]    r_tag_mem    [Entries];
  logic [31:0]        r_target_mem [Entries];

  logic [IDX_W-1:0] w_ridx;
  logic [TagW-1:0]  w_rtag;
  logic [IDX_W-1:0] w_widx;
  logic [TagW-1:0]  w_wtag;

  assign w_ridx = lookup_pc_i[IDX_W+1:2];
  assign w_rtag = lookup_pc_i[31:IDX_W+2];
  assign w_widx = wpc_i[IDX_W+1:2];
  assign w_wtag = wpc_i[31:IDX_W+2];

  // Lookup reads the pre-write contents, so a same-cycle write is seen next cycle.
  assign hit_o    = r_valid[w_ridx] && (r_tag_mem[w_ridx] == w_rtag);
  assign target_o = r_target_mem[w_ridx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (we_i) begin
      r_valid[w_widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      r_tag_mem[w_widx]    <= w_wtag;
      r_target_mem[w_widx] <= wtarget_i;
    end
  end

endmodule

// File: rtl/if_pc_gen.sv
// IF-stage fetch PC generator with BTB-based next-PC prediction and EX redirect.
// Optional macro IF_PC_GEN_PERF_CNT_EN adds saturating redirect/taken-fire counters.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter int                     BTB_IDX_W = BtbIdxW,
  parameter logic [InstAddrBus-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  output logic [InstAddrBus-1:0] pc_o,
  input  logic                   pre_taken_i,
  output logic                   if_valid_o,
  input  logic                   if_ready_i,
  output logic                   pred_taken_o,
  output logic [InstAddrBus-1:0] pred_target_o,
  input  logic                   ex_redirect_i,
  input  logic [InstAddrBus-1:0] ex_redirect_pc_i,
  input  logic                   ex_upd_i,
  input  logic [InstAddrBus-1:0] ex_upd_pc_i,
  input  logic                   ex_upd_taken_i,
  input  logic [InstAddrBus-1:0] ex_upd_target_i,
  output logic                   pred_we_o,
  output logic [InstAddrBus-1:0] pred_waddr_o,
  output logic                   pred_res_taken_o
`ifdef IF_PC_GEN_PERF_CNT_EN
  ,
  output logic [31:0]            perf_redirect_o,
  output logic [31:0]            perf_pred_taken_o
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [InstAddrBus-1:0] r_pc;
  logic [InstAddrBus-1:0] w_pc_next;
  logic                   r_hold_taken;
  logic [InstAddrBus-1:0] r_hold_next;
  logic                   w_hold_load;

  logic                   r_pred_we;
  logic [InstAddrBus-1:0] r_pred_waddr;
  logic                   r_pred_res_taken;

  logic                   w_btb_hit;
  logic [InstAddrBus-1:0] w_btb_target;
  logic                   w_btb_we;
  logic                   w_taken;
  logic [InstAddrBus-1:0] w_next;
  logic [InstAddrBus-1:0] w_redirect_pc;
  logic                   w_fire;

  if_pc_gen_btb_table #(
    .IDX_W(BTB_IDX_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc_i(r_pc[31:2]),
    .hit_o      (w_btb_hit),
    .target_o   (w_btb_target),
    .we_i       (w_btb_we),
    .wpc_i      (ex_upd_pc_i[31:2]),
    .wtarget_i  (ex_upd_target_i)
  );

  // Only taken branches allocate; not-taken resolutions leave the BTB alone.
  assign w_btb_we      = rdy & ex_upd_i & ex_upd_taken_i;
  assign w_taken       = w_btb_hit & pre_taken_i;
  assign w_next        = w_taken ? w_btb_target : pc_plus4(r_pc);
  assign w_redirect_pc = ex_redirect_pc_i & 32'hFFFF_FFFC;
  assign w_fire        = rdy & if_valid_o & if_ready_i;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_hold_load  = 1'b0;
    if (rdy) begin
      if (ex_redirect_i) begin
        w_pc_next    = w_redirect_pc;
        w_state_next = RUN;
      end else begin
        case (r_state)
          BOOT: w_state_next = RUN;
          RUN: begin
            if (w_fire) begin
              w_pc_next = w_next;
            end else begin
              w_hold_load  = 1'b1;
              w_state_next = HOLD;
            end
          end
          HOLD: begin
            if (w_fire) begin
              w_pc_next    = r_hold_next;
              w_state_next = RUN;
            end
          end
          default: w_state_next = BOOT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_hold_taken <= 1'b0;
      r_hold_next  <= pc_plus4(RESET_PC);
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_hold_load) begin
        r_hold_taken <= w_taken;
        r_hold_next  <= w_next;
      end
    end
  end

  // Resolution forward to the direction predictor, exactly one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_we        <= 1'b0;
      r_pred_waddr     <= '0;
      r_pred_res_taken <= 1'b0;
    end else if (rdy) begin
      r_pred_we <= ex_upd_i;
      if (ex_upd_i) begin
        r_pred_waddr     <= ex_upd_pc_i;
        r_pred_res_taken <= ex_upd_taken_i;
      end
    end
  end

  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = pc_plus4(r_pc);
    case (r_state)
      RUN: begin
        pred_taken_o  = w_taken;
        pred_target_o = w_next;
      end
      HOLD: begin
        pred_taken_o  = r_hold_taken;
        pred_target_o = r_hold_next;
      end
      default: ;
    endcase
  end

  assign pc_o             = r_pc;
  assign if_valid_o       = (r_state != BOOT);
  assign pred_we_o        = r_pred_we;
  assign pred_waddr_o     = r_pred_waddr;
  assign pred_res_taken_o = r_pred_res_taken;

`ifdef IF_PC_GEN_PERF_CNT_EN
  logic [31:0] r_perf_redirect;
  logic [31:0] r_perf_pred_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_redirect   <= '0;
      r_perf_pred_taken <= '0;
    end else if (rdy) begin
      if (ex_redirect_i && (r_perf_redirect != 32'hFFFF_FFFF)) begin
        r_perf_redirect <= r_perf_redirect + 32'd1;
      end
      if (w_fire && pred_taken_o && (r_perf_pred_taken != 32'hFFFF_FFFF)) begin
        r_perf_pred_taken <= r_perf_pred_taken + 32'd1;
      end
    end
  end

  assign perf_redirect_o   = r_perf_redirect;
  assign perf_pred_taken_o = r_perf_pred_taken;
`endif

endmodule

// File: tb/tb_if_pc_gen.sv
// Self-checking bench for if_pc_gen: scoreboarded fetch PCs plus per-feature checks.
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        pre_taken_i = 1'b0;
  logic        if_ready_i = 1'b0;
  logic        ex_redirect_i = 1'b0;
  logic [31:0] ex_redirect_pc_i = 32'h0;
  logic        ex_upd_i = 1'b0;
  logic [31:0] ex_upd_pc_i = 32'h0;
  logic        ex_upd_taken_i = 1'b0;
  logic [31:0] ex_upd_target_i = 32'h0;

  logic [31:0] pc_o;
  logic        if_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        pred_we_o;
  logic [31:0] pred_waddr_o;
  logic        pred_res_taken_o;

  int          total = 0;
  int          bad = 0;
  logic [31:0] q_exp[$];
  logic [31:0] exp_v;
  logic [31:0] saved_pc;

  always #5 clk = ~clk;

  if_pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .pc_o            (pc_o),
    .pre_taken_i     (pre_taken_i),
    .if_valid_o      (if_valid_o),
    .if_ready_i      (if_ready_i),
    .pred_taken_o    (pred_taken_o),
    .pred_target_o   (pred_target_o),
    .ex_redirect_i   (ex_redirect_i),
    .ex_redirect_pc_i(ex_redirect_pc_i),
    .ex_upd_i        (ex_upd_i),
    .ex_upd_pc_i     (ex_upd_pc_i),
    .ex_upd_taken_i  (ex_upd_taken_i),
    .ex_upd_target_i (ex_upd_target_i),
    .pred_we_o       (pred_we_o),
    .pred_waddr_o    (pred_waddr_o),
    .pred_res_taken_o(pred_res_taken_o)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want %h", pc_o, 32'h0); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", if_valid_o); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL rst_ptaken: got %b want 0", pred_taken_o); end
    total++; if (pred_target_o !== 32'h4) begin bad++; $display("FAIL rst_ptarget: got %h want %h", pred_target_o, 32'h4); end
    total++; if (pred_we_o !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", pred_we_o); end
    total++; if (pred_waddr_o !== 32'h0) begin bad++; $display("FAIL rst_waddr: got %h want 0", pred_waddr_o); end
    total++; if (pred_res_taken_o !== 1'b0) begin bad++; $display("FAIL rst_res: got %b want 0", pred_res_taken_o); end
    rst = 1'b0;
    rdy = 1'b1;
    if_ready_i = 1'b1;
    pre_taken_i = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_sequential();
    q_exp.push_back(32'h0);
    q_exp.push_back(32'h4);
    q_exp.push_back(32'h8);
    q_exp.push_back(32'hC);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = q_exp.pop_front();
      total++; if (pc_o !== exp_v) begin bad++; $display("FAIL seq_pc: got %h want %h", pc_o, exp_v); end
      total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL seq_valid: got %b want 1", if_valid_o); end
      total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL seq_ptaken: got %b want 0", pred_taken_o); end
      $display("seq fetch pc=%h", pc_o);
    end
  endtask

  task automatic test_btb_hit();
    ex_upd_i = 1'b1; ex_upd_pc_i = 32'h10; ex_upd_taken_i = 1'b1; ex_upd_target_i = 32'h80;
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h10;
    q_exp.push_back(32'h10);
    step();
    ex_upd_i = 1'b0; ex_redirect_i = 1'b0;
    #1;
    exp_v = q_exp.pop_front();
    total++; if (pc_o !== exp_v) begin bad++; $display("FAIL hit_pc: got %h want %h", pc_o, exp_v); end
    total++; if (pred_taken_o !== 1'b1) begin bad++; $display("FAIL hit_ptaken: got %b want 1", pred_taken_o); end
    total++; if (pred_target_o !== 32'h80) begin bad++; $display("FAIL hit_ptarget: got %h want 80", pred_target_o); end
    total++; if (pred_we_o !== 1'b1) begin bad++; $display("FAIL hit_we: got %b want 1", pred_we_o); end
    total++; if (pred_waddr_o !== 32'h10) begin bad++; $display("FAIL hit_waddr: got %h want 10", pred_waddr_o); end
    total++; if (pred_res_taken_o !== 1'b1) begin bad++; $display("FAIL hit_res: got %b want 1", pred_res_taken_o); end
    q_exp.push_back(32'h80);
    step();
    exp_v = q_exp.pop_front();
    total++; if (pc_o !== exp_v) begin bad++; $display("FAIL hit_next: got %h want %h", pc_o, exp_v); end
    total++; if (pred_we_o !== 1'b0) begin bad++; $display("FAIL hit_we_clr: got %b want 0", pred_we_o); end
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h10; pre_taken_i = 1'b0;
    step();
    ex_redirect_i = 1'b0;
    #1;
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL nt_ptaken: got %b want 0", pred_taken_o); end
    total++; if (pred_target_o !== 32'h14) begin bad++; $display("FAIL nt_ptarget: got %h want 14", pred_target_o); end
    q_exp.push_back(32'h14);
    step();
    exp_v = q_exp.pop_front();
    total++; if (pc_o !== exp_v) begin bad++; $display("FAIL nt_next: got %h want %h", pc_o, exp_v); end
    $display("btb hit/not-taken checked pc=%h", pc_o);
  endtask

  task automatic test_hold();
    pre_taken_i = 1'b1;
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h10;
    step();
    ex_redirect_i = 1'b0; if_ready_i = 1'b0;
    #1;
    total++; if (pred_target_o !== 32'h80) begin bad++; $display("FAIL hold_pre_target: got %h want 80", pred_target_o); end
    step();
    ex_upd_i = 1'b1; ex_upd_pc_i = 32'h10; ex_upd_taken_i = 1'b1; ex_upd_target_i = 32'h40;
    step();
    ex_upd_i = 1'b0; pre_taken_i = 1'b0;
    #1;
    total++; if (pred_target_o !== 32'h80) begin bad++; $display("FAIL hold_target: got %h want 80", pred_target_o); end
    total++; if (pred_taken_o !== 1'b1) begin bad++; $display("FAIL hold_ptaken: got %b want 1", pred_taken_o); end
    total++; if (pc_o !== 32'h10) begin bad++; $display("FAIL hold_pc: got %h want 10", pc_o); end
    total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b want 1", if_valid_o); end
    if_ready_i = 1'b1;
    q_exp.push_back(32'h80);
    step();
    exp_v = q_exp.pop_front();
    total++; if (pc_o !== exp_v) begin bad++; $display("FAIL hold_release: got %h want %h", pc_o, exp_v); end
    pre_taken_i = 1'b1;
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h10;
    step();
    ex_redirect_i = 1'b0;
    #1;
    total++; if (pred_target_o !== 32'h40) begin bad++; $display("FAIL btb_rewrite: got %h want 40", pred_target_o); end
    $display("hold checked pc=%h", pc_o);
  endtask

  task automatic test_redirect_in_hold();
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h80; if_ready_i = 1'b1;
    step();
    ex_redirect_i = 1'b0; if_ready_i = 1'b0;
    step();
    total++; if (pc_o !== 32'h80) begin bad++; $display("FAIL rdh_hold_pc: got %h want 80", pc_o); end
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h203; if_ready_i = 1'b1;
    q_exp.push_back(32'h200);
    step();
    ex_redirect_i = 1'b0;
    exp_v = q_exp.pop_front();
    total++; if (pc_o !== exp_v) begin bad++; $display("FAIL rdh_pc: got %h want %h", pc_o, exp_v); end
    q_exp.push_back(32'h204);
    step();
    exp_v = q_exp.pop_front();
    total++; if (pc_o !== exp_v) begin bad++; $display("FAIL rdh_run_next: got %h want %h", pc_o, exp_v); end
    $display("redirect in hold checked pc=%h", pc_o);
  endtask

  task automatic test_upd_not_taken();
    ex_upd_i = 1'b1; ex_upd_pc_i = 32'h24; ex_upd_taken_i = 1'b0; ex_upd_target_i = 32'h99;
    step();
    ex_upd_i = 1'b0;
    total++; if (pred_we_o !== 1'b1) begin bad++; $display("FAIL upd_we: got %b want 1", pred_we_o); end
    total++; if (pred_waddr_o !== 32'h24) begin bad++; $display("FAIL upd_waddr: got %h want 24", pred_waddr_o); end
    total++; if (pred_res_taken_o !== 1'b0) begin bad++; $display("FAIL upd_res: got %b want 0", pred_res_taken_o); end
    step();
    total++; if (pred_we_o !== 1'b0) begin bad++; $display("FAIL upd_we_clr: got %b want 0", pred_we_o); end
    rdy = 1'b0;
    ex_upd_i = 1'b1; ex_upd_pc_i = 32'h30; ex_upd_taken_i = 1'b1; ex_upd_target_i = 32'h300;
    saved_pc = pc_o;
    step();
    total++; if (pc_o !== saved_pc) begin bad++; $display("FAIL frz_pc: got %h want %h", pc_o, saved_pc); end
    total++; if (pred_we_o !== 1'b0) begin bad++; $display("FAIL frz_we: got %b want 0", pred_we_o); end
    ex_upd_i = 1'b0; rdy = 1'b1; pre_taken_i = 1'b1;
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h30;
    step();
    ex_redirect_i = 1'b0;
    #1;
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL frz_btb: got %b want 0", pred_taken_o); end
    total++; if (pred_target_o !== 32'h34) begin bad++; $display("FAIL frz_target: got %h want 34", pred_target_o); end
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h24;
    step();
    ex_redirect_i = 1'b0;
    #1;
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL nt_btb: got %b want 0", pred_taken_o); end
    total++; if (pred_target_o !== 32'h28) begin bad++; $display("FAIL nt_target: got %h want 28", pred_target_o); end
    $display("update forward checked pc=%h", pc_o);
  endtask

  task automatic test_async_reset();
    pre_taken_i = 1'b1; if_ready_i = 1'b0;
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h10;
    step();
    ex_redirect_i = 1'b0;
    ex_upd_i = 1'b1; ex_upd_pc_i = 32'h44; ex_upd_taken_i = 1'b0;
    step();
    ex_upd_i = 1'b0;
    #1;
    total++; if (pred_we_o !== 1'b1) begin bad++; $display("FAIL ar_pending: got %b want 1", pred_we_o); end
    total++; if (pred_target_o !== 32'h40) begin bad++; $display("FAIL ar_hold_target: got %h want 40", pred_target_o); end
    #1 rst = 1'b1;
    #1;
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL ar_pc: got %h want 0", pc_o); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", if_valid_o); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL ar_ptaken: got %b want 0", pred_taken_o); end
    total++; if (pred_target_o !== 32'h4) begin bad++; $display("FAIL ar_ptarget: got %h want 4", pred_target_o); end
    total++; if (pred_we_o !== 1'b0) begin bad++; $display("FAIL ar_we: got %b want 0", pred_we_o); end
    @(negedge clk);
    rst = 1'b0; if_ready_i = 1'b1;
    step();
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h10;
    step();
    ex_redirect_i = 1'b0;
    #1;
    total++; if (pc_o !== 32'h10) begin bad++; $display("FAIL ar_redir_pc: got %h want 10", pc_o); end
    total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL ar_btb_miss: got %b want 0", pred_taken_o); end
    total++; if (pred_target_o !== 32'h14) begin bad++; $display("FAIL ar_btb_target: got %h want 14", pred_target_o); end
    $display("async reset checked pc=%h", pc_o);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_btb_hit();
    test_hold();
    test_redirect_in_hold();
    test_upd_not_taken();
    test_async_reset();
    if (q_exp.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_left: got %0d want 0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- Fetch-address generator for the IF stage; sits directly upstream of the 2-bit branch predictor and the icache.
- Holds the fetch PC and drives it as the predictor read address.
- Owns a direct-mapped BTB; combines the BTB hit/target with pre_taken_i to pick the next PC.
- Applies EX-stage redirects and forwards branch resolutions to the predictor write port, registered once.

Parameters:
- BTB_IDX_W, 6, log2 of BTB entries (64).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global enable; 0 freezes all state. Outputs hold, and no BTB or predictor writes occur.
- pc_o  out  32  current fetch address; also drives predictor raddr_i.
- pre_taken_i  in  1  predictor direction for pc_o (combinational from pc_o).
- if_valid_o  out  1  fetch request valid.
- if_ready_i  in  1  icache/IF accepts request this cycle.
- pred_taken_o  out  1  prediction metadata travelling with the fetched instruction.
- pred_target_o  out  32  predicted next PC travelling with the fetched instruction.
- ex_redirect_i  in  1  mispredict or exception redirect.
- ex_redirect_pc_i  in  32  correct PC.
- ex_upd_i  in  1  branch resolved this cycle.
- ex_upd_pc_i  in  32  PC of the resolved branch.
- ex_upd_taken_i  in  1  actual direction.
- ex_upd_target_i  in  32  actual target.
- pred_we_o  out  1  to predictor we_i.
- pred_waddr_o  out  32  to predictor waddr_i.
- pred_res_taken_o  out  1  to predictor res_taken.

Behaviour:
- Reset values: pc_o=RESET_PC, if_valid_o=0, pred_taken_o=0, pred_target_o=RESET_PC+4, pred_we_o=0, pred_waddr_o=0, pred_res_taken_o=0. All BTB valid bits are cleared; state=BOOT.
- Reset asserted mid-operation discards any held request and any pending update.
- Handshake: fire = rdy & if_valid_o & if_ready_i.
- BTB lookup, combinational on pc_o:
  - idx = pc_o[BTB_IDX_W+1:2]; tag = pc_o[31:BTB_IDX_W+2].
  - hit = valid[idx] & (tag_mem[idx]==tag).
  - taken = hit & pre_taken_i.
  - next = taken ? target_mem[idx] : pc_o+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
- FSM:
  - BOOT: if_valid_o=0. Next cycle (rdy=1) goes to RUN.
  - RUN: if_valid_o=1, and pred_taken_o/pred_target_o show the live lookup.
    - On fire: pc_o<=next; stay in RUN.
    - If valid and not ready: latch taken/next into hold registers; go to HOLD.
  - HOLD: if_valid_o=1, and pred_taken_o/pred_target_o come from the hold registers. They stay stable even if the BTB or predictor changes.
    - On fire: pc_o<=held next; go to RUN.
- Redirect has top priority in every state. On ex_redirect_i & rdy:
  - pc_o<=ex_redirect_pc_i with bits[1:0] forced to 0; state<=RUN.
  - The current request is dropped; the consumer flushes on the same redirect.
  - A fire in the same cycle is ignored for PC purposes.
- BTB write: on ex_upd_i & ex_upd_taken_i & rdy, write valid/tag/target at the index of ex_upd_pc_i.
  - Not-taken updates never touch the BTB.
  - A same-cycle lookup of the same index sees the old entry (write at posedge).
- Predictor forward: on every ex_upd_i & rdy, register pred_we_o=1, pred_waddr_o=ex_upd_pc_i, pred_res_taken_o=ex_upd_taken_i. This is exactly one cycle of latency; pred_we_o=0 otherwise.
- Simultaneous redirect and update are both honoured.

Optional Feature:
- Macro: IF_PC_GEN_PERF_CNT_EN.
- Defined: adds outputs perf_redirect_o[31:0] (count of ex_redirect_i & rdy) and perf_pred_taken_o[31:0] (count of fires with a taken prediction). Both are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- Undefined: no such ports or counters exist; all other behaviour is identical.

Decomposition:
- Shared defines header: InstAddrBus, BtbIdxW, BtbTagW, RESET_PC default, and FSM state encodings BOOT/RUN/HOLD (2-bit).
- One sub-module, btb_table: storage plus combinational lookup and a write port, with asynchronous clear of the valid bits.

Test Plan:
- Reset then rdy=1, if_ready_i=1, empty BTB, pre_taken_i=1 -> BOOT 1 cycle, then pc_o sequence 0,4,8,12; pred_taken_o=0 throughout.
- ex_upd pc=0x10, taken=1, target=0x80; later fetch at 0x10 with pre_taken_i=1 -> pred_taken_o=1, pred_target_o=0x80, next pc_o=0x80. Same fetch with pre_taken_i=0 -> next pc_o=0x14.
- if_ready_i=0 at pc 0x10 (taken, target 0x80), then a BTB update changes entry 0x10 target to 0x40 -> HOLD keeps pred_target_o=0x80 and pc_o=0x10. On ready, pc_o=0x80.
- Redirect to 0x203 while in HOLD and with if_ready_i=1 same cycle -> next pc_o=0x200, state RUN.
- ex_upd pc=0x24, taken=0 -> pred_we_o=1, pred_waddr_o=0x24, pred_res_taken_o=0 one cycle later; BTB unchanged; rdy=0 during the update -> no write.
- Async rst asserted mid-HOLD -> outputs return to reset values immediately, and BTB lookups miss.
